// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle signed restoring divider (quotient to LO, remainder to HI)
//
// Ports:
//   clock, reset_n         rising-edge clock, asynchronous active-low reset
//   start                  request; accepted only while busy=0
//   dividend, divisor      signed operands, sampled when start is accepted
//   busy                   high while an operation is in flight (CALC and FIX)
//   done                   one-cycle pulse; quotient/remainder valid from this cycle
//   quotient, remainder    signed results, held until the next completed operation
//   div_by_zero            only when SEQ_DIV_DZ_FLAG_EN is defined: set by a divide by zero,
//                          cleared at the next accepted start
//
// Optional feature macro: SEQ_DIV_DZ_FLAG_EN

module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
`ifdef SEQ_DIV_DZ_FLAG_EN
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
`else
    output logic [WIDTH-1:0] remainder
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] r_reg;
    logic [WIDTH-1:0] d_mag;
    logic             sign_a;
    logic             sign_q;
    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   r_trial;
    logic             fits;
`ifdef SEQ_DIV_DZ_FLAG_EN
    logic             dz_op;
`endif

    // Magnitude as WIDTH-bit unsigned: the most negative value maps to 2^(WIDTH-1) exactly.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + 1'b1) : v;
    endfunction

    // One restoring step: shift the next dividend bit into R, try subtracting |divisor|.
    // R < |divisor| <= 2^(WIDTH-1), so the shifted value fits in WIDTH+1 bits and the
    // borrow out of the trial subtraction is the "does not fit" indication.
    always_comb begin
        r_shift = {r_reg, q_reg[WIDTH-1]};
        r_trial = r_shift - {1'b0, d_mag};
        fits    = ~r_trial[WIDTH];
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = (divisor == '0) ? FIX : CALC;
            CALC: if (count == '0) state_next = FIX;
            FIX:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            done      <= 1'b0;
            count     <= '0;
            q_reg     <= '0;
            r_reg     <= '0;
            d_mag     <= '0;
            sign_a    <= 1'b0;
            sign_q    <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
`ifdef SEQ_DIV_DZ_FLAG_EN
            dz_op       <= 1'b0;
            div_by_zero <= 1'b0;
`endif
        end else begin
            state <= state_next;
            done  <= (state == FIX);
            case (state)
                IDLE: begin
                    if (start) begin
                        sign_a <= dividend[WIDTH-1];
                        d_mag  <= mag(divisor);
                        count  <= CW'(WIDTH - 1);
                        r_reg  <= '0;
                        if (divisor == '0) begin
                            // Preload the divide-by-zero result so FIX needs no special case:
                            // Q = all-ones unsigned, R = |dividend| re-signed to the dividend.
                            sign_q <= 1'b0;
                            q_reg  <= '1;
                            r_reg  <= mag(dividend);
                        end else begin
                            sign_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                            q_reg  <= mag(dividend);
                        end
`ifdef SEQ_DIV_DZ_FLAG_EN
                        dz_op       <= (divisor == '0);
                        div_by_zero <= 1'b0;
`endif
                    end
                end
                CALC: begin
                    r_reg <= fits ? r_trial[WIDTH-1:0] : r_shift[WIDTH-1:0];
                    q_reg <= {q_reg[WIDTH-2:0], fits};
                    count <= count - 1'b1;
                end
                FIX: begin
                    quotient  <= sign_q ? (~q_reg + 1'b1) : q_reg;
                    remainder <= sign_a ? (~r_reg + 1'b1) : r_reg;
`ifdef SEQ_DIV_DZ_FLAG_EN
                    div_by_zero <= dz_op;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - self-checking bench for seq_divider (vector table + random vs reference model)

module tb_seq_divider;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
`ifdef SEQ_DIV_DZ_FLAG_EN
    logic        div_by_zero;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    seq_divider #(.WIDTH(32)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
`ifdef SEQ_DIV_DZ_FLAG_EN
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
`else
        .remainder  (remainder)
`endif
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: signed division on 64-bit integers (truncates toward zero,
    // remainder follows dividend), then wrapped to 32 bits.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (b == 32'd0) return {32'hFFFF_FFFF, a};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        return {q[31:0], r[31:0]};
    endfunction

    // Issue one operation and wait for done; returns edges counted after the accept edge.
    task automatic issue_and_wait(input logic [31:0] a, input logic [31:0] b,
                                  output int edges, output int busy_bad, output int glitch);
        logic [31:0] q_hold;
        logic [31:0] r_hold;
        q_hold = quotient;
        r_hold = remainder;
        @(negedge clock);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        edges    = 0;
        busy_bad = 0;
        glitch   = 0;
        while (!done && edges < 100) begin
            @(posedge clock);
            #1;
            edges++;
            if (!done) begin
                if (busy !== 1'b1) busy_bad++;
                if (quotient !== q_hold || remainder !== r_hold) glitch++;
            end
        end
    endtask

    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er);
        int edges;
        int busy_bad;
        int glitch;
        issue_and_wait(a, b, edges, busy_bad, glitch);
        chk({name, " latency"}, edges, (b == 32'd0) ? 32'd1 : 32'd33);
        chk({name, " quotient"}, quotient, eq);
        chk({name, " remainder"}, remainder, er);
        chk({name, " busy_in_flight"}, busy_bad, 32'd0);
        chk({name, " no_glitch"}, glitch, 32'd0);
        chk({name, " busy_at_done"}, {31'd0, busy}, 32'd0);
`ifdef SEQ_DIV_DZ_FLAG_EN
        chk({name, " dz_flag"}, {31'd0, div_by_zero}, {31'd0, (b == 32'd0)});
`endif
        @(posedge clock);
        #1;
        chk({name, " done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        vec_t vecs[$];
        logic [63:0] m;
        logic [31:0] a;
        logic [31:0] b;
        int edges;
        int busy_bad;
        int glitch;
        int k;

        vecs.push_back('{32'd100, 32'd7, 32'd14, 32'd2});
        vecs.push_back('{-32'sd100, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE});
        vecs.push_back('{32'd100, -32'sd7, 32'hFFFF_FFF2, 32'd2});
        vecs.push_back('{-32'sd100, -32'sd7, 32'd14, 32'hFFFF_FFFE});
        vecs.push_back('{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0});
        vecs.push_back('{32'h7FFF_FFFF, 32'd1, 32'h7FFF_FFFF, 32'd0});
        vecs.push_back('{32'd55, 32'd0, 32'hFFFF_FFFF, 32'd55});
        vecs.push_back('{-32'sd55, 32'd0, 32'hFFFF_FFFF, -32'sd55});
        vecs.push_back('{32'h8000_0000, 32'h8000_0000, 32'd1, 32'd0});
        vecs.push_back('{32'd5, 32'h8000_0000, 32'd0, 32'd5});
        vecs.push_back('{32'd3, 32'd10, 32'd0, 32'd3});
        vecs.push_back('{32'd0, -32'sd9, 32'd0, 32'd0});

        reset_n  = 1'b0;
        start    = 1'b0;
        dividend = 32'd0;
        divisor  = 32'd0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset quotient", quotient, 32'd0);
        chk("reset remainder", remainder, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r);

        // start while busy is ignored; a start in the done cycle is accepted with no bubble
        @(negedge clock);
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clock);
        @(negedge clock);
        dividend = 32'd9;
        divisor  = 32'd3;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        edges = 5;
        while (!done && edges < 100) begin
            @(posedge clock);
            #1;
            edges++;
        end
        chk("busy_start latency", edges, 32'd33);
        chk("busy_start quotient", quotient, 32'd14);
        chk("busy_start remainder", remainder, 32'd2);
        dividend = 32'd9;
        divisor  = 32'd3;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        chk("b2b accepted busy", {31'd0, busy}, 32'd1);
        edges = 0;
        while (!done && edges < 100) begin
            @(posedge clock);
            #1;
            edges++;
        end
        chk("b2b latency", edges, 32'd33);
        chk("b2b quotient", quotient, 32'd3);
        chk("b2b remainder", remainder, 32'd0);

        // asynchronous reset in the middle of an operation
        @(negedge clock);
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        chk("midreset busy", {31'd0, busy}, 32'd0);
        chk("midreset done", {31'd0, done}, 32'd0);
        chk("midreset quotient", quotient, 32'd0);
        chk("midreset remainder", remainder, 32'd0);
        k = 0;
        repeat (3) begin
            @(posedge clock);
            #1;
            if (done) k++;
        end
        @(negedge clock);
        reset_n = 1'b1;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (done) k++;
        end
        chk("midreset no_done", k, 32'd0);
        run_op("post_reset", 32'd20, 32'd6, 32'd3, 32'd2);

        // randomized operands against the reference model
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            case (i % 4)
                0: b = $urandom;
                1: b = $urandom_range(1, 20);
                2: b = -$urandom_range(1, 20);
                default: b = (i % 8 == 3) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
            endcase
            m = model(a, b);
            issue_and_wait(a, b, edges, busy_bad, glitch);
            chk($sformatf("rand%0d latency", i), edges, (b == 32'd0) ? 32'd1 : 32'd33);
            chk($sformatf("rand%0d quotient %h/%h", i, a, b), quotient, m[63:32]);
            chk($sformatf("rand%0d remainder %h/%h", i, a, b), remainder, m[31:0]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
